hazard_ctrl_mc: RTL
===================

Name: hazard_ctrl_mc

Overview:
Parametrised load-use hazard and stall controller for the 5-stage RISC-V pipeline. It is the successor to the single-bubble hazard detector. It compares ID-stage source registers against the EX-stage load destination and inserts a configurable number of bubbles. It also freezes the whole pipeline while the data memory reports busy, and generates the IF/ID flush for taken branches. A saturating performance counter records stall cycles.

Parameters:
REG_W, 5, register index width
LU_STALL, 1, bubbles inserted per load-use hazard (legal 1..7)
CNT_W, 3, width of internal bubble counter (must hold LU_STALL)
PERF_W, 32, width of stall-cycle performance counter
ZERO_SKIP, 1, 1 = source/destination x0 never creates a hazard

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
id_rs1_i  in  REG_W  rs1 of instruction in ID
id_rs2_i  in  REG_W  rs2 of instruction in ID
id_rs1_used_i  in  1  instruction in ID reads rs1
id_rs2_used_i  in  1  instruction in ID reads rs2
ex_rd_i  in  REG_W  rd of instruction in EX
ex_memread_i  in  1  instruction in EX is a load
mem_busy_i  in  1  data memory not ready; hold all stages
branch_taken_i  in  1  branch in ID resolved taken
pc_write_o  out  1  PC update enable
if_id_write_o  out  1  IF/ID register write enable
id_ex_noop_o  out  1  zero control bits entering ID/EX
if_id_flush_o  out  1  clear IF/ID on taken branch
hold_all_o  out  1  freeze every pipeline register (memory wait)
busy_o  out  1  FSM not in IDLE
stall_cnt_o  out  PERF_W  saturating count of cycles with pc_write_o = 0

Behaviour:
- Hazard term HZ = ex_memread_i & ((id_rs1_used_i & id_rs1_i == ex_rd_i) | (id_rs2_used_i & id_rs2_i == ex_rd_i)). If ZERO_SKIP = 1, HZ is forced to 0 when ex_rd_i == 0.
- The FSM has three states: IDLE, LU_WAIT, MEM_WAIT. Registered state: FSM state, bubble counter cnt, stall_cnt_o.
- Reset (rst_i high at a clock edge): state = IDLE, cnt = 0, stall_cnt_o = 0. While rst_i is high, outputs are forced to pc_write_o = 1, if_id_write_o = 1, id_ex_noop_o = 0, if_id_flush_o = 0, hold_all_o = 0, busy_o = 0. Reset mid-stall abandons the remaining bubbles.
- Priority within a cycle: rst_i > mem_busy_i > LU_WAIT/HZ > branch_taken_i.
- mem_busy_i = 1 in any state:
  - outputs: hold_all_o = 1, pc_write_o = 0, if_id_write_o = 0, id_ex_noop_o = 0, if_id_flush_o = 0.
  - If state was IDLE, the next state is MEM_WAIT. Otherwise the state and cnt are frozen.
- MEM_WAIT with mem_busy_i = 0: return to the state saved on entry, which is always IDLE. Outputs are evaluated as IDLE in that same cycle.
- IDLE, no busy, HZ = 1:
  - outputs: pc_write_o = 0, if_id_write_o = 0, id_ex_noop_o = 1, if_id_flush_o = 0 (flush is suppressed because the branch operand is not ready).
  - If LU_STALL > 1: next state = LU_WAIT, cnt = LU_STALL - 1. Otherwise remain in IDLE.
- LU_WAIT, no busy:
  - outputs: same as the HZ case above, independent of current HZ. This is needed because the load has left EX, so ex_rd_i no longer matches.
  - cnt decrements each cycle. When cnt == 1, the next state = IDLE with cnt = 0.
  - Total bubbles per hazard = exactly LU_STALL.
- IDLE, no busy, HZ = 0: pc_write_o = 1, if_id_write_o = 1, id_ex_noop_o = 0, if_id_flush_o = branch_taken_i.
- busy_o = 1 in LU_WAIT and MEM_WAIT.
- stall_cnt_o increments by 1 on every non-reset edge where pc_write_o = 0. It saturates at all-ones with no wrap.
- All outputs are combinational from state and inputs; there is zero-cycle latency from HZ to the stall outputs.

Test Plan:
1. Reset, then ex_memread_i = 1, ex_rd_i = 5, id_rs1_i = 5, rs1 used, LU_STALL = 1 -> exactly one cycle with pc_write_o = 0 and id_ex_noop_o = 1, busy_o stays 0, stall_cnt_o = 1.
2. LU_STALL = 3, same hazard, with ex_memread_i dropped after cycle 1 -> three consecutive bubble cycles, busy_o = 1 in cycles 2-3, then IDLE; stall_cnt_o = 3.
3. ex_rd_i = 0 matching id_rs2_i = 0 with ZERO_SKIP = 1 -> no stall. With id_rs1_used_i = 0 and rs1 matching -> no stall.
4. LU_STALL = 3, mem_busy_i pulsed high for 4 cycles in the second bubble cycle -> hold_all_o = 1 for 4 cycles, then the remaining 2 bubbles complete; stall_cnt_o = 7.
5. branch_taken_i = 1 with HZ = 1 -> if_id_flush_o = 0 and a bubble is inserted. Next cycle, HZ = 0 and branch_taken_i = 1 -> if_id_flush_o = 1 and pc_write_o = 1.
6. rst_i asserted during LU_WAIT with cnt = 2 -> the next cycle is IDLE with pc_write_o = 1 and stall_cnt_o = 0. With PERF_W = 3, holding the stall for 10 cycles -> stall_cnt_o saturates at 7.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// Load-use hazard and stall controller for the 5-stage pipeline: multi-bubble
// load-use stalls, whole-pipeline freeze on data-memory wait, and IF/ID flush.
module hazard_ctrl_mc #(
  parameter int REG_W     = 5,
  parameter int LU_STALL  = 1,
  parameter int CNT_W     = 3,
  parameter int PERF_W    = 32,
  parameter int ZERO_SKIP = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_W-1:0]  id_rs1_i,
  input  logic [REG_W-1:0]  id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_W-1:0]  ex_rd_i,
  input  logic              ex_memread_i,
  input  logic              mem_busy_i,
  input  logic              branch_taken_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              id_ex_noop_o,
  output logic              if_id_flush_o,
  output logic              hold_all_o,
  output logic              busy_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  stall_cnt_q;
  logic               rs_match;
  logic               hz;

  // A load writing x0 never produces a usable value, so it cannot be a hazard.
  assign rs_match = (id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                    (id_rs2_used_i && (id_rs2_i == ex_rd_i));
  assign hz       = ex_memread_i && rs_match &&
                    !((ZERO_SKIP != 0) && (ex_rd_i == '0));

  // NOTE: every output and next-state variable gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    id_ex_noop_o  = 1'b0;
    if_id_flush_o = 1'b0;
    hold_all_o    = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;

    if (rst_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (mem_busy_i) begin
      hold_all_o    = 1'b1;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if (state_q == IDLE) state_d = MEM_WAIT;
    end else begin
      case (state_q)
        LU_WAIT: begin
          // The load has left EX, so the bubble no longer depends on hz.
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          id_ex_noop_o  = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          // IDLE, and MEM_WAIT releasing back to IDLE, share one decision.
          state_d = IDLE;
          if (hz) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_noop_o  = 1'b1;
            if (LU_STALL > 1) begin
              state_d = LU_WAIT;
              cnt_d   = CNT_W'(LU_STALL - 1);
            end
          end else begin
            if_id_flush_o = branch_taken_i;
          end
        end
      endcase
    end
  end

  assign busy_o      = !rst_i && (state_q != IDLE);
  assign stall_cnt_o = stall_cnt_q;

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_write_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
    end
  end

endmodule
